// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR packet reader: bus widths, descriptor
// layout, reader FSM states and the length-to-beat-count helper.
package ddr_pkg;

    localparam int DDR_ADDR_W     = 25;
    localparam int DDR_DATA_W     = 256;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_BEAT = 8;

    // Descriptor beat: payload length in bytes lives in the low 16 bits.
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = 16;

    // Wide enough for ceil(65535/32) = 2048 beats.
    localparam int BEAT_CNT_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_REQ  = 3'd1,
        ST_HDR_WAIT = 3'd2,
        ST_DATA     = 3'd3,
        ST_DONE     = 3'd4
    } rd_state_t;

    // Beats needed for a payload: ceil(ceil(len/4)/8) == ceil(len/32).
    function automatic logic [BEAT_CNT_W-1:0] beats_for_len(input logic [LEN_W-1:0] len);
        return {1'b0, len[15:5]} + {11'b0, |len[4:0]};
    endfunction

endpackage

// File: rtl/ddr_beat_fifo.sv
// Beat buffer between the Avalon read-data return and the word unpacker.
// The head entry is visible combinationally on o_head_data so the unpacker
// can slice words out of it without first moving it to a holding register.
// Ports:
//   avalon_clk, avalon_reset : clock, async active-high reset
//   i_push, i_push_data      : write one beat
//   i_pop                    : retire the head beat
//   o_head_data              : current head beat
//   o_full, o_empty, o_count : occupancy status
module ddr_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 256,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             avalon_clk,
    input  logic             avalon_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge avalon_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_packet_reader.sv
// Avalon-MM read master that fetches a packet image from DDR and replays it
// as a 32-bit valid/ready word stream with SOP/EOP/empty flags.
// A descriptor beat at base_addr holds the byte length; payload beats follow
// at base_addr+1.. and are unpacked word 0 first.
// Ports:
//   avalon_clk, avalon_reset           : clock, async active-high reset
//   start, base_addr                   : launch a transfer (accepted only when idle)
//   busy, done, error                  : status; error qualifies the done pulse
//   amm_*                              : Avalon-MM read master (single-beat reads)
//   out_data/valid/ready/sop/eop/empty : registered word stream
//
// state    | meaning
// IDLE     | waiting for start
// HDR_REQ  | descriptor read presented, waiting for amm_ready
// HDR_WAIT | waiting for descriptor data, length checked on arrival
// DATA     | issuing payload reads and streaming words out
// DONE     | one-cycle done (and error) pulse
module ddr_packet_reader
    import ddr_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [15:0] MAX_LEN   = 16'd2048
) (
    input  logic                  avalon_clk,
    input  logic                  avalon_reset,
    input  logic                  start,
    input  logic [DDR_ADDR_W-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DDR_ADDR_W-1:0] amm_addr,
    output logic                  amm_read,
    output logic [6:0]            amm_burstcount,
    output logic [31:0]           amm_byteenable,
    input  logic                  amm_ready,
    input  logic [DDR_DATA_W-1:0] amm_readdata,
    input  logic                  amm_readdatavalid,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [1:0]            out_empty
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_t r_state, w_state_nxt;

    logic [DDR_ADDR_W-1:0] r_base;
    logic [BEAT_CNT_W-1:0] r_nb;
    logic [BEAT_CNT_W-1:0] r_issued;
    logic [BEAT_CNT_W-1:0] r_popped;
    logic [CNT_W-1:0]      r_outstanding;
    logic [2:0]            r_last_idx;
    logic [1:0]            r_empty_eop;
    logic                  r_error;
    logic [2:0]            r_widx;
    logic                  r_first;
    logic [WORD_W-1:0]     r_out_data;
    logic                  r_out_valid;
    logic                  r_out_sop;
    logic                  r_out_eop;
    logic [1:0]            r_out_empty;

    logic                  w_rdv;
    logic [LEN_W-1:0]      w_len;
    logic                  w_len_bad;
    logic                  w_credit;
    logic                  w_amm_read;
    logic                  w_accept;
    logic [DDR_ADDR_W-1:0] w_req_addr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_last_beat;
    logic                  w_beat_end;
    logic                  w_eop_hs;
    logic [WORD_W-1:0]     w_word;
    logic [DDR_DATA_W-1:0] w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;

    // Read data is only meaningful while a request is in flight; this also
    // drops returns for requests abandoned by a reset.
    assign w_rdv     = amm_readdatavalid && (r_outstanding != '0);
    assign w_len     = amm_readdata[LEN_LSB +: LEN_W];
    assign w_len_bad = (w_len == '0) || (w_len > MAX_LEN);

    // Every in-flight read must have a guaranteed FIFO slot on return.
    assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
    assign w_amm_read = (r_state == ST_HDR_REQ) ||
                        ((r_state == ST_DATA) && (r_issued < r_nb) && w_credit);
    assign w_accept   = w_amm_read && amm_ready;
    assign w_req_addr = (r_state == ST_HDR_REQ) ? r_base
                                                : r_base + DDR_ADDR_W'(1) + DDR_ADDR_W'(r_issued);

    assign w_push = w_rdv && (r_state == ST_DATA) && !w_fifo_full;

    // Unpacker: the head beat stays in the FIFO until its last word has been
    // moved into the output register, so occupancy counts it for credit.
    assign w_last_beat = (r_popped == r_nb - BEAT_CNT_W'(1));
    assign w_beat_end  = w_last_beat ? (r_widx == r_last_idx) : (r_widx == 3'd7);
    assign w_load      = (r_state == ST_DATA) && !w_fifo_empty && (!r_out_valid || out_ready);
    assign w_pop       = w_load && w_beat_end;
    assign w_word      = w_fifo_head[{r_widx, 5'b0} +: WORD_W];
    assign w_eop_hs    = r_out_valid && out_ready && r_out_eop;

    ddr_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DDR_DATA_W)
    ) u_fifo (
        .avalon_clk  (avalon_clk),
        .avalon_reset(avalon_reset),
        .i_push      (w_push),
        .i_push_data (amm_readdata),
        .i_pop       (w_pop),
        .o_head_data (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_state_nxt = ST_HDR_REQ;
            ST_HDR_REQ:  if (amm_ready) w_state_nxt = ST_HDR_WAIT;
            ST_HDR_WAIT: if (w_rdv) w_state_nxt = w_len_bad ? ST_DONE : ST_DATA;
            ST_DATA:     if (w_eop_hs) w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            r_base        <= '0;
            r_nb          <= '0;
            r_issued      <= '0;
            r_popped      <= '0;
            r_outstanding <= '0;
            r_last_idx    <= '0;
            r_empty_eop   <= '0;
            r_error       <= 1'b0;
            r_widx        <= '0;
            r_first       <= 1'b0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_empty   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_base  <= base_addr;
                r_error <= 1'b0;
            end

            if ((r_state == ST_HDR_WAIT) && w_rdv) begin
                r_nb        <= beats_for_len(w_len);
                // (ceil(len/4) - 1) mod 8: index of the EOP word in the last beat
                r_last_idx  <= w_len[4:2] + {2'b0, |w_len[1:0]} - 3'd1;
                r_empty_eop <= 2'd0 - w_len[1:0];
                r_error     <= w_len_bad;
                r_issued    <= '0;
                r_popped    <= '0;
                r_widx      <= '0;
                r_first     <= 1'b1;
            end

            if ((r_state == ST_DATA) && w_accept) begin
                r_issued <= r_issued + BEAT_CNT_W'(1);
            end

            case ({w_accept, w_rdv})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_load) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
                r_out_sop   <= r_first;
                r_out_eop   <= w_last_beat && w_beat_end;
                r_out_empty <= (w_last_beat && w_beat_end) ? r_empty_eop : 2'd0;
                r_first     <= 1'b0;
                r_widx      <= w_beat_end ? 3'd0 : r_widx + 3'd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_pop) begin
                r_popped <= r_popped + BEAT_CNT_W'(1);
            end
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign error          = (r_state == ST_DONE) && r_error;
    assign amm_read       = w_amm_read;
    assign amm_addr       = w_amm_read ? w_req_addr : '0;
    assign amm_burstcount = 7'd1;
    assign amm_byteenable = '1;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign out_sop        = r_out_sop;
    assign out_eop        = r_out_eop;
    assign out_empty      = r_out_empty;

endmodule

// File: tb/tb_ddr_packet_reader.sv
module tb_ddr_packet_reader;

    localparam int          DEPTH = 2;
    localparam logic [15:0] MAXL  = 16'd2048;

    logic          avalon_clk = 1'b0;
    logic          avalon_reset = 1'b1;
    logic          start = 1'b0;
    logic [24:0]   base_addr = '0;
    logic          busy, done, error;
    logic [24:0]   amm_addr;
    logic          amm_read;
    logic [6:0]    amm_burstcount;
    logic [31:0]   amm_byteenable;
    logic          amm_ready = 1'b1;
    logic [255:0]  amm_readdata = '0;
    logic          amm_readdatavalid = 1'b0;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sop, out_eop;
    logic [1:0]    out_empty;

    always #5 avalon_clk = ~avalon_clk;

    ddr_packet_reader #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL)) dut (
        .avalon_clk(avalon_clk), .avalon_reset(avalon_reset),
        .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .error(error),
        .amm_addr(amm_addr), .amm_read(amm_read),
        .amm_burstcount(amm_burstcount), .amm_byteenable(amm_byteenable),
        .amm_ready(amm_ready), .amm_readdata(amm_readdata),
        .amm_readdatavalid(amm_readdatavalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty)
    );

    typedef struct {
        logic [24:0]  addr;
        int           due;
        logic [255:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
    } word_t;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [24:0] cur_base = '0;
    logic [15:0] cur_len  = '0;
    int lat_v = 5, rdy_mode = 0, ord_mode = 0;

    rsp_t        sq[$];
    logic [24:0] rd_log[$];
    word_t       wlog[$];
    int hold_err = 0, valid_cyc = 0, max_credit = 0;
    int acc_pl = 0, popped = 0, loads = 0, wait_cnt = 0;
    logic prev_valid = 1'b0, prev_hs = 1'b0, prev_pending = 1'b0;
    logic [24:0] prev_addr = '0;

    always @(posedge avalon_clk) cyc <= cyc + 1;

    function automatic logic [255:0] beat_of(input logic [24:0] a);
        logic [255:0] b;
        if (a == cur_base) begin
            b = {{240{1'b1}}, cur_len};
        end else begin
            for (int k = 0; k < 8; k++) b[32*k +: 32] = {8'hC3, a[15:0], 5'd0, 3'(k)};
        end
        return b;
    endfunction

    // Avalon slave model, output sink and credit/hold observers.
    always @(negedge avalon_clk) begin
        if (out_valid && (!prev_valid || prev_hs)) begin
            if (out_eop || (loads % 8 == 7)) popped++;
            loads++;
        end
        if (out_valid) valid_cyc++;
        if (acc_pl - popped > max_credit) max_credit = acc_pl - popped;
        if (prev_pending && !avalon_reset && (!amm_read || amm_addr != prev_addr)) hold_err++;

        if (rdy_mode == 1 && amm_read && wait_cnt < 3) begin
            amm_ready = 1'b0;
            wait_cnt++;
        end else begin
            amm_ready = 1'b1;
        end
        if (amm_read && amm_ready) begin
            wait_cnt = 0;
            rd_log.push_back(amm_addr);
            if (amm_addr != cur_base) acc_pl++;
            sq.push_back('{amm_addr, cyc + lat_v, beat_of(amm_addr)});
        end
        prev_pending = amm_read && !amm_ready && !avalon_reset;
        prev_addr    = amm_addr;

        if (sq.size() > 0 && sq[0].due <= cyc) begin
            amm_readdatavalid = 1'b1;
            amm_readdata      = sq[0].data;
            void'(sq.pop_front());
        end else begin
            amm_readdatavalid = 1'b0;
        end

        out_ready = (ord_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        prev_hs = out_valid && out_ready;
        if (prev_hs) wlog.push_back('{out_data, out_sop, out_eop, out_empty});
        prev_valid = out_valid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge avalon_clk);
        #2;
    endtask

    task automatic clr();
        rd_log.delete();
        wlog.delete();
        hold_err = 0; valid_cyc = 0; max_credit = 0;
        acc_pl = 0; popped = 0; loads = 0;
    endtask

    task automatic run_pkt(input string nm, input logic [24:0] base, input logic [15:0] len,
                           input int lt, input int rm, input int om, input int poke);
        int nw, nb, emp, errs;
        logic exp_err, got_done, got_err;
        logic [24:0] a;
        word_t w;
        nw = (int'(len) + 3) / 4;
        nb = (nw + 7) / 8;
        emp = (4 - int'(len) % 4) % 4;
        exp_err = (len == 16'd0) || (len > MAXL);
        cur_base = base; cur_len = len; lat_v = lt; rdy_mode = rm; ord_mode = om;
        clr();
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = '0;
        chk({nm, " read_at_cycle1"}, amm_read, 1);
        chk({nm, " hdr_addr"}, amm_addr, base);
        chk({nm, " busy"}, busy, 1);

        got_done = 1'b0;
        got_err  = 1'b0;
        for (int n = 0; n < 3000 && !got_done; n++) begin
            if (done) begin
                got_done = 1'b1;
                got_err  = error;
            end else begin
                if (n == poke) begin
                    start = 1'b1;
                    base_addr = 25'h0ABCDE;
                end else begin
                    start = 1'b0;
                end
                tick();
            end
        end
        start = 1'b0;
        chk({nm, " done_seen"}, got_done, 1);
        chk({nm, " error"}, got_err, exp_err);
        tick();
        chk({nm, " done_one_cycle"}, done, 0);
        chk({nm, " busy_after"}, busy, 0);

        chk({nm, " read_count"}, rd_log.size(), exp_err ? 1 : 1 + nb);
        errs = 0;
        for (int i = 0; i < rd_log.size(); i++) begin
            a = base + 25'(i);
            if (rd_log[i] !== a) errs++;
        end
        chk({nm, " read_addrs"}, errs, 0);
        chk({nm, " addr_hold"}, hold_err, 0);
        chk({nm, " credit_le_depth"}, (max_credit <= DEPTH), 1);

        chk({nm, " word_count"}, wlog.size(), exp_err ? 0 : nw);
        if (exp_err) begin
            chk({nm, " no_valid"}, valid_cyc, 0);
        end else begin
            errs = 0;
            for (int i = 0; i < nw && i < wlog.size(); i++) begin
                a = base + 25'(1 + i / 8);
                w = wlog[i];
                if (w.d !== {8'hC3, a[15:0], 5'd0, 3'(i % 8)}) errs++;
                if (w.sop !== (i == 0)) errs++;
                if (w.eop !== (i == nw - 1)) errs++;
                if (w.emp !== ((i == nw - 1) ? 2'(emp) : 2'd0)) errs++;
            end
            chk({nm, " stream"}, errs, 0);
            if (wlog.size() == nw) begin
                chk({nm, " eop_empty"}, wlog[nw-1].emp, emp);
            end
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst amm_read", amm_read, 0);
        chk("rst amm_addr", amm_addr, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst done_error", {done, error}, 0);
        chk("rst burstcount", amm_burstcount, 1);
        chk("rst byteenable", amm_byteenable, 32'hFFFF_FFFF);
        avalon_reset = 1'b0;
        tick();

        run_pkt("len64",      25'h100,     16'd64,   5, 0, 0, -1);
        run_pkt("len46",      25'h1000,    16'd46,   5, 0, 0, 4);
        run_pkt("rdy_stall",  25'h100,     16'd64,   5, 1, 0, -1);
        run_pkt("oready_1of3", 25'h2000,   16'd256,  5, 0, 1, -1);
        run_pkt("len0",       25'h3000,    16'd0,    5, 0, 0, 1);
        run_pkt("len_max+1",  25'h3100,    16'd2049, 5, 0, 0, 2);
        run_pkt("len_max",    25'h5000,    16'd2048, 5, 0, 0, -1);
        run_pkt("addr_wrap",  25'h1FFFFFF, 16'd40,   3, 0, 0, -1);

        // Reset in the middle of DATA with reads still in flight.
        cur_base = 25'h300; cur_len = 16'd256; lat_v = 20; rdy_mode = 0; ord_mode = 0;
        clr();
        base_addr = 25'h300;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 29; n++) tick();
        chk("rst_mid busy_before", busy, 1);
        chk("rst_mid reads_pending", (sq.size() > 0), 1);
        avalon_reset = 1'b1;
        #1;
        chk("rst_mid busy", busy, 0);
        chk("rst_mid amm", {amm_read, amm_addr}, 0);
        chk("rst_mid out", {out_valid, out_sop, out_eop, out_empty, out_data}, 0);
        chk("rst_mid done_error", {done, error}, 0);
        tick();
        tick();
        avalon_reset = 1'b0;
        clr();
        for (int n = 0; n < 100 && sq.size() > 0; n++) tick();
        chk("rst_mid stale_drained", sq.size(), 0);
        tick();
        tick();
        chk("rst_mid stale_no_valid", valid_cyc, 0);
        chk("rst_mid stale_idle", busy, 0);
        chk("rst_mid stale_no_read", rd_log.size(), 0);
        run_pkt("after_rst", 25'h400, 16'd101, 5, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_packet_reader.md
# ddr_packet_reader

Avalon-MM read master that fetches a packet image previously written into DDR by the setup writer and replays it as a 32-bit word stream toward the SFP transmit path. On `start` it reads a descriptor beat at `base_addr`, derives the payload length, issues single-beat reads for the payload, buffers returned 256-bit beats, and unpacks them into 32-bit words with valid/ready handshake, SOP/EOP and byte-empty flags. It sits between the `avalon_mm_ddr`-style DDR port and the transmit datapath, entirely in the `avalon_clk` domain.

## Interface
- `FIFO_DEPTH`, 4: beat-buffer depth (power of two, ≥2); also the maximum number of outstanding reads.
- `MAX_LEN`, 16'd2048: largest legal payload length in bytes.
- `avalon_clk` in 1: clock.
- `avalon_reset` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request; ignored unless `busy`=0.
- `base_addr` in 25: descriptor beat address; sampled when `start` is accepted.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse at end of transfer or on error.
- `error` out 1: valid with `done`; 1 = illegal length.
- `amm_addr` out 25; `amm_read` out 1; `amm_burstcount` out 7 (constant 1); `amm_byteenable` out 32 (constant all-ones).
- `amm_ready` in 1: slave accepts request when high.
- `amm_readdata` in 256; `amm_readdatavalid` in 1.
- `out_data` out 32; `out_valid` out 1; `out_ready` in 1.
- `out_sop` out 1; `out_eop` out 1; `out_empty` out 2: invalid trailing bytes in the EOP word.

## Operation
- Memory layout: descriptor beat at `base_addr`, bits [15:0] = payload length LEN in bytes, rest ignored. Payload beats at `base_addr+1 … base_addr+NB`; word k of a beat is bits [32k+31:32k], k=0 sent first.
- NW = ceil(LEN/4); NB = ceil(NW/8); `out_empty` = (4 − LEN mod 4) mod 4 on the EOP word, 0 elsewhere. Address arithmetic 25-bit, wraps modulo 2^25.
- States: IDLE → HDR_REQ (assert `amm_read`, `amm_addr`=base) → HDR_WAIT (await `amm_readdatavalid`) → DATA → DONE → IDLE.
- HDR_WAIT: LEN=0 or LEN>MAX_LEN → DONE with `error`=1, no stream output.
- DATA: request issue allowed when requests_issued < NB and (outstanding + FIFO occupancy) < FIFO_DEPTH; returned beats pushed to FIFO; unpacker pops a beat, emits words 0..7 (last beat: only up to word (NW−1) mod 8). Leaves DATA after the EOP word handshakes.
- DONE: `done`=1, `busy`=0 next cycle.
- Reset values: all outputs 0 (`amm_burstcount`=1, `amm_byteenable`='1 constant); state IDLE, FIFO empty, counters cleared. Reset mid-transfer abandons it; read data arriving after reset deassertion with no outstanding request is discarded.

## Timing
- `start` at cycle 0 → `amm_read`=1 at cycle 1.
- `amm_read`/`amm_addr` held stable until a cycle with `amm_ready`=1; request consumed that edge; next request may be presented the following cycle.
- `readdatavalid` data is pushed into FIFO at that edge, never stalled; credit rule guarantees no overflow.
- First payload beat in FIFO at edge t → `out_valid`=1 with `out_sop` from t+1.
- Output registered, AXI-style: `out_data`/flags stable while `out_valid`=1 and `out_ready`=0; word advances on each `out_valid & out_ready` edge; back-to-back words one per cycle across beat boundaries if the next beat is buffered.
- `done` pulses the cycle after the EOP handshake (or the cycle after the descriptor returns on error).
- Simultaneous FIFO push and pop in the same cycle are both honoured.

## Structure
- Shared package `ddr_pkg`: state enum, `DDR_ADDR_W`=25, `DDR_DATA_W`=256, `WORDS_PER_BEAT`=8, descriptor length field position.
- Sub-module `ddr_beat_fifo`: synchronous 256-bit FIFO, parameter DEPTH, push/pop/full/empty/count, async reset on `avalon_reset`.

## Test plan
- LEN=64, base 0x100, `amm_ready`=1, latency 5, `out_ready`=1 → reads at 0x100,0x101,0x102; 16 words, SOP on word 0, EOP on word 15, `out_empty`=0, `done`=1, `error`=0.
- LEN=46 → NW=12, NB=2; EOP on word 11 (second beat word 3), `out_empty`=2; no third payload read.
- `amm_ready` low 3 cycles per request → `amm_addr`/`amm_read` held stable; same word stream as case 1.
- `out_ready` toggling 1-of-3 cycles, LEN=256 (4 beats), FIFO_DEPTH=2 → outstanding+occupancy never exceeds 2, no lost/duplicated words, order preserved.
- LEN=0 and LEN=MAX_LEN+1 → no payload read, no `out_valid`, `done`=`error`=1 one cycle; `start` during `busy` ignored.
- `avalon_reset` asserted mid-DATA with reads outstanding → all outputs 0 immediately; new `start` after release yields a correct packet despite stale `readdatavalid`.
